// File: rtl/player_motion_ctrl_if.sv
// Purpose : bundles the keyboard/level-geometry inputs and sprite-state outputs of the player controller.
// Latency : wires only, no storage.
// Backpressure: none; every signal is level-valued and sampled every clock.
// Ports   : master drives keyboard_data, rect_bounds, rect_kind and observes X, Y, win, dead, airborne;
//           slave (the controller) takes the inputs and drives the sprite state.
interface player_motion_ctrl_if #(
  parameter int NUM_RECTS = 4
);
  logic [7:0]             keyboard_data;
  logic [NUM_RECTS*36-1:0] rect_bounds;   // per rect {bottom,top,right,left}, 9 b each, rect 0 at LSBs
  logic [NUM_RECTS*2-1:0]  rect_kind;     // 00 unused, 01 solid, 10 hazard, 11 goal
  logic [8:0]             X;
  logic [8:0]             Y;
  logic                   win;
  logic                   dead;
  logic                   airborne;

  modport master (
    output keyboard_data, rect_bounds, rect_kind,
    input  X, Y, win, dead, airborne
  );

  modport slave (
    input  keyboard_data, rect_bounds, rect_kind,
    output X, Y, win, dead, airborne
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Purpose : player sprite position controller: walk, jump/fall FSM, screen clamp, sticky win/dead flags.
// Latency : key code is registered, then acts on the next move tick; all outputs are registered.
// Backpressure: none; the held key is sampled every clock and the outputs are free-running.
// Ports   : clock, reset (async, active-low), bus (player_motion_ctrl_if.slave):
//           keyboard_data, rect_bounds, rect_kind in; X, Y, win, dead, airborne out.
// Option  : define PLAYER_DOUBLE_JUMP_EN to allow one extra jump per airborne spell on a fresh
//           jump press; without it airborne jump presses are ignored.
module player_motion_ctrl #(
  parameter int         X_START    = 0,
  parameter int         Y_START    = 0,
  parameter int         SCREEN_W   = 320,
  parameter int         SCREEN_H   = 240,
  parameter int         SPRITE_W   = 20,
  parameter int         SPRITE_H   = 20,
  parameter int         NUM_RECTS  = 4,
  parameter int         JUMP_COUNT = 35,
  parameter int         STEP_X     = 1,
  parameter int         STEP_Y     = 2,
  parameter int         TICK_DIV   = 1,
  parameter logic [7:0] KEY_LEFT   = 8'h6B,
  parameter logic [7:0] KEY_RIGHT  = 8'h74,
  parameter logic [7:0] KEY_JUMP   = 8'h75
) (
  input logic                 clock,
  input logic                 reset,
  player_motion_ctrl_if.slave bus
);

  localparam logic [1:0] KIND_SOLID  = 2'b01;
  localparam logic [1:0] KIND_HAZARD = 2'b10;
  localparam logic [1:0] KIND_GOAL   = 2'b11;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (JUMP_COUNT > 1) ? $clog2(JUMP_COUNT) : 1;

  // Encoding chosen so state[1] is exactly the airborne output (RISE/FALL).
  typedef enum logic [1:0] {
    GROUND = 2'b00,
    DONE   = 2'b01,
    RISE   = 2'b10,
    FALL   = 2'b11
  } state_t;

  state_t           state;
  logic [8:0]       x_q;
  logic [8:0]       y_q;
  logic             win_q;
  logic             dead_q;
  logic [CNT_W-1:0] jump_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       key_q;

  logic tick;
  logic key_left, key_right, key_jump;
  logic hit_l, hit_r, hit_u, hit_d;
  logic blk_l, blk_r, blk_u, blk_d;
  logic hazard_hit, goal_hit;
  logic dj_take;

  logic [9:0] xw, yw;
  logic [35:0] rb;
  logic [1:0]  rk;

  // Sprite box at (bx,by) against one rect; 10-bit math so x+SPRITE_W never wraps.
  function automatic logic box_hit(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [35:0] r);
    logic [9:0] left, right, top, bottom;
    left   = {1'b0, r[8:0]};
    right  = {1'b0, r[17:9]};
    top    = {1'b0, r[26:18]};
    bottom = {1'b0, r[35:27]};
    return (bx < right) && ((bx + 10'(SPRITE_W)) > left) &&
           (by < bottom) && ((by + 10'(SPRITE_H)) > top);
  endfunction

  assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign key_left  = (key_q == KEY_LEFT);
  assign key_right = (key_q == KEY_RIGHT);
  assign key_jump  = (key_q == KEY_JUMP);
  assign xw        = {1'b0, x_q};
  assign yw        = {1'b0, y_q};

  // Probe boxes one step away in each direction; underflowed probes are masked
  // by the screen-edge terms of the blocked flags below.
  always_comb begin
    hit_l      = 1'b0;
    hit_r      = 1'b0;
    hit_u      = 1'b0;
    hit_d      = 1'b0;
    hazard_hit = 1'b0;
    goal_hit   = 1'b0;
    rb         = '0;
    rk         = '0;
    for (int r = 0; r < NUM_RECTS; r++) begin
      rb = bus.rect_bounds[r*36 +: 36];
      rk = bus.rect_kind[r*2 +: 2];
      if (rk == KIND_SOLID) begin
        hit_l = hit_l | box_hit(xw - 10'(STEP_X), yw, rb);
        hit_r = hit_r | box_hit(xw + 10'(STEP_X), yw, rb);
        hit_u = hit_u | box_hit(xw, yw - 10'(STEP_Y), rb);
        hit_d = hit_d | box_hit(xw, yw + 10'(STEP_Y), rb);
      end
      if (rk == KIND_HAZARD) hazard_hit = hazard_hit | box_hit(xw, yw, rb);
      if (rk == KIND_GOAL)   goal_hit   = goal_hit   | box_hit(xw, yw, rb);
    end
  end

  assign blk_l = (xw < 10'(STEP_X)) || hit_l;
  assign blk_r = ((xw + 10'(SPRITE_W) + 10'(STEP_X)) > 10'(SCREEN_W)) || hit_r;
  assign blk_u = (yw < 10'(STEP_Y)) || hit_u;
  assign blk_d = ((yw + 10'(SPRITE_H) + 10'(STEP_Y)) > 10'(SCREEN_H)) || hit_d;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic jump_hist;  // key_jump as seen on the previous tick
  logic dj_used;
  assign dj_take = state[1] && key_jump && !jump_hist && !dj_used;
`else
  assign dj_take = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q      <= 9'(X_START);
      y_q      <= 9'(Y_START);
      win_q    <= 1'b0;
      dead_q   <= 1'b0;
      state    <= FALL;
      jump_cnt <= '0;
      div_cnt  <= '0;
      key_q    <= 8'h00;
`ifdef PLAYER_DOUBLE_JUMP_EN
      jump_hist <= 1'b0;
      dj_used   <= 1'b0;
`endif
    end else begin
      key_q   <= bus.keyboard_data;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (state != DONE) begin
        // Touch checks run every clock and freeze the sprite where it touched.
        if (hazard_hit) begin
          dead_q <= 1'b1;
          state  <= DONE;
        end else if (goal_hit) begin
          win_q <= 1'b1;
          state <= DONE;
        end else if (tick) begin
          // Horizontal and vertical both decided from the pre-tick position.
          if (key_left && !blk_l)
            x_q <= x_q - 9'(STEP_X);
          else if (key_right && !blk_r)
            x_q <= x_q + 9'(STEP_X);
`ifdef PLAYER_DOUBLE_JUMP_EN
          jump_hist <= key_jump;
`endif
          if (dj_take) begin
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used <= 1'b1;
`endif
            state    <= RISE;
            jump_cnt <= '0;
          end else begin
            case (state)
              GROUND: begin
                if (key_jump) begin
                  state    <= RISE;
                  jump_cnt <= '0;
                end else if (!blk_d) begin
                  state <= FALL;
                end
              end
              RISE: begin
                if (!blk_u) y_q <= y_q - 9'(STEP_Y);
                jump_cnt <= jump_cnt + 1'b1;
                // jump_cnt counts completed rise ticks, so this is the JUMP_COUNT-th one.
                if (blk_u || (jump_cnt == CNT_W'(JUMP_COUNT - 1))) state <= FALL;
              end
              FALL: begin
                if (!blk_d) begin
                  y_q <= y_q + 9'(STEP_Y);
                end else begin
                  state <= GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
                  dj_used <= 1'b0;
`endif
                end
              end
              DONE: ;
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.X        = x_q;
  assign bus.Y        = y_q;
  assign bus.win      = win_q;
  assign bus.dead     = dead_q;
  assign bus.airborne = state[1];

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Purpose : self-checking bench for player_motion_ctrl; scoreboard of per-clock expected outputs
//           from a behavioural model, plus fixed-value checks for landing, apex, clamps and flags.
// Clock   : 10 time-unit period; inputs change on the falling edge, outputs sampled 1 unit after rise.
module tb_player_motion_ctrl;
  localparam int TD  = 2;     // clocks per move tick
  localparam int NR  = 4;
  localparam int SW  = 20;
  localparam int SH  = 20;
  localparam int SCW = 320;
  localparam int SCH = 240;
  localparam int SX  = 1;
  localparam int SY  = 2;
  localparam int JC  = 35;
  localparam logic [7:0] K_L = 8'h6B;
  localparam logic [7:0] K_R = 8'h74;
  localparam logic [7:0] K_J = 8'h75;
  localparam int M_GROUND = 0, M_RISE = 1, M_FALL = 2, M_DONE = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  player_motion_ctrl_if #(.NUM_RECTS(NR)) bus ();

  player_motion_ctrl #(.NUM_RECTS(NR), .TICK_DIV(TD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       win;
    logic       dead;
    logic       air;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int checks = 0;
  int failures = 0;

  // Level geometry as the model sees it.
  int rl[NR], rt[NR], rr[NR], rbt[NR], rk[NR];
  // Model state.
  int mx, my, mwin, mdead, mmode, mcnt, mdiv, mkey, mprev, mdj;
  int miny;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_rect(input int i, input int kind, input int l, input int t,
                          input int r, input int b);
    rl[i] = l; rt[i] = t; rr[i] = r; rbt[i] = b; rk[i] = kind;
    bus.rect_bounds[i*36 +: 36] = {9'(b), 9'(t), 9'(r), 9'(l)};
    bus.rect_kind[i*2 +: 2]     = 2'(kind);
  endtask

  task automatic clear_rects();
    for (int i = 0; i < NR; i++) set_rect(i, 0, 0, 0, 0, 0);
  endtask

  function automatic bit hit(input int kind, input int x, input int y);
    for (int i = 0; i < NR; i++)
      if (rk[i] == kind && x < rr[i] && x + SW > rl[i] && y < rbt[i] && y + SH > rt[i])
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mwin = 0; mdead = 0; mmode = M_FALL;
    mcnt = 0; mdiv = 0; mkey = 0; mprev = 0; mdj = 0;
  endtask

  // One clock of the game rules: key seen is the one registered on the previous clock.
  task automatic model_clock(input logic [7:0] kb);
    int k, nx;
    bit tk, bl, br, bu, bd, jmp;
    k    = mkey;
    tk   = (mdiv == TD - 1);
    mkey = int'(kb);
    mdiv = tk ? 0 : mdiv + 1;
    if (mmode == M_DONE) return;
    if (hit(2, mx, my)) begin mdead = 1; mmode = M_DONE; return; end
    if (hit(3, mx, my)) begin mwin = 1; mmode = M_DONE; return; end
    if (!tk) return;
    bl  = (mx < SX) || hit(1, mx - SX, my);
    br  = (mx + SW + SX > SCW) || hit(1, mx + SX, my);
    bu  = (my < SY) || hit(1, mx, my - SY);
    bd  = (my + SH + SY > SCH) || hit(1, mx, my + SY);
    jmp = (k == int'(K_J));
    nx  = mx;
    if (k == int'(K_L) && !bl) nx = mx - SX;
    else if (k == int'(K_R) && !br) nx = mx + SX;
`ifdef PLAYER_DOUBLE_JUMP_EN
    if ((mmode == M_RISE || mmode == M_FALL) && jmp && !mprev && !mdj) begin
      mmode = M_RISE; mcnt = 0; mdj = 1; mprev = 1; mx = nx;
      return;
    end
    mprev = jmp;
`endif
    case (mmode)
      M_GROUND: begin
        if (jmp) begin mmode = M_RISE; mcnt = 0; end
        else if (!bd) mmode = M_FALL;
      end
      M_RISE: begin
        if (!bu) my = my - SY;
        mcnt++;
        if (bu || mcnt == JC) mmode = M_FALL;
      end
      M_FALL: begin
        if (!bd) my = my + SY;
        else begin mmode = M_GROUND; mdj = 0; end
      end
      default: ;
    endcase
    mx = nx;
  endtask

  task automatic push_exp();
    exp_t e;
    e.x    = 9'(mx);
    e.y    = 9'(my);
    e.win  = (mwin != 0);
    e.dead = (mdead != 0);
    e.air  = (mmode == M_RISE || mmode == M_FALL);
    exp_q.push_back(e);
  endtask

  // Both tasks start and end just after a falling edge.
  task automatic run(input logic [7:0] kb, input int n);
    for (int i = 0; i < n; i++) begin
      bus.keyboard_data = kb;
      model_clock(kb);
      push_exp();
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    bus.keyboard_data = 8'h00;
    model_reset();
    for (int i = 0; i < n; i++) begin
      push_exp();
      @(negedge clock);
    end
    reset = 1'b1;
  endtask

  // Monitor: every rising edge with an expectation pending, pop and compare.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {bus.X, bus.Y, bus.win, bus.dead, bus.airborne};
        checks++;
        if (mon_a !== mon_e) begin
          failures++;
          $display("FAIL scoreboard t=%0t: got X=%0d Y=%0d win=%0b dead=%0b air=%0b, expected X=%0d Y=%0d win=%0b dead=%0b air=%0b",
                   $time, mon_a.x, mon_a.y, mon_a.win, mon_a.dead, mon_a.air,
                   mon_e.x, mon_e.y, mon_e.win, mon_e.dead, mon_e.air);
        end
      end
    end
  end

  initial begin
    bus.keyboard_data = 8'h00;
    bus.rect_bounds   = '0;
    bus.rect_kind     = '0;
    model_reset();
    @(negedge clock);

    // Floor only: fall, land, clamp left, one jump, clamp right.
    clear_rects();
    set_rect(0, 1, 0, 220, 320, 240);
    do_reset(3);
    run(8'h00, 220);
    chk("land_y", bus.Y, 200);
    chk("land_air", bus.airborne, 0);
    run(K_L, 10);
    chk("left_clamp_x", bus.X, 0);
    run(K_J, 2);
    miny = 511;
    for (int i = 0; i < 120; i++) begin
      run(8'h00, 1);
      if (bus.Y < miny) miny = bus.Y;
    end
    chk("apex_y", miny, 130);
    run(8'h00, 100);
    chk("reland_y", bus.Y, 200);
    chk("reland_air", bus.airborne, 0);
    run(K_R, 700);
    chk("right_clamp_x", bus.X, 300);

    // Solid wall with left edge at 150.
    clear_rects();
    set_rect(0, 1, 0, 220, 320, 240);
    set_rect(1, 1, 150, 0, 200, 220);
    do_reset(2);
    run(K_R, 500);
    chk("wall_x", bus.X, 130);

    // Goal on the floor: win freezes the sprite.
    clear_rects();
    set_rect(0, 1, 0, 220, 320, 240);
    set_rect(1, 3, 296, 200, 306, 223);
    do_reset(2);
    run(8'h00, 210);
    run(K_R, 600);
    chk("goal_win", bus.win, 1);
    chk("goal_dead", bus.dead, 0);
    chk("goal_x", bus.X, 277);
    run(K_L, 20);
    chk("goal_frozen_x", bus.X, 277);

    // Hazard and goal on the same spot: hazard takes priority.
    clear_rects();
    set_rect(0, 1, 0, 220, 320, 240);
    set_rect(1, 3, 296, 200, 306, 223);
    set_rect(2, 2, 296, 200, 306, 223);
    do_reset(2);
    run(8'h00, 210);
    run(K_R, 600);
    chk("both_dead", bus.dead, 1);
    chk("both_win", bus.win, 0);

    // Asynchronous reset in the middle of a rise.
    clear_rects();
    set_rect(0, 1, 0, 220, 320, 240);
    do_reset(2);
    run(8'h00, 210);
    run(K_R, 20);
    run(K_J, 2);
    run(8'h00, 20);
    chk("midrise_air", bus.airborne, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_x", bus.X, 0);
    chk("async_y", bus.Y, 0);
    chk("async_win", bus.win, 0);
    chk("async_dead", bus.dead, 0);
    chk("async_air", bus.airborne, 1);
    @(negedge clock);
    do_reset(2);
    run(8'h00, 10);

`ifdef PLAYER_DOUBLE_JUMP_EN
    // Re-press at the apex, then a third press that must be ignored.
    run(8'h00, 210);
    run(K_J, 2);
    run(8'h00, 68);
    run(K_J, 4);
    run(8'h00, 20);
    run(K_J, 4);
    run(8'h00, 300);
`endif

    // Randomized geometry and key sequences.
    for (int s = 0; s < 6; s++) begin
      int cyc, n, l, t;
      logic [7:0] key;
      clear_rects();
      set_rect(0, 1, 0, 220, 320, 240);
      for (int i = 1; i < NR; i++) begin
        l = int'($urandom_range(0, 300));
        t = int'($urandom_range(0, 220));
        set_rect(i, int'($urandom_range(0, 3)), l, t,
                 l + int'($urandom_range(1, 60)), t + int'($urandom_range(1, 40)));
      end
      do_reset(2);
      cyc = 0;
      while (cyc < 1500) begin
        case ($urandom_range(0, 5))
          0:       key = 8'h00;
          1:       key = K_L;
          2, 3:    key = K_R;
          4:       key = K_J;
          default: key = 8'h1C;
        endcase
        n = int'($urandom_range(1, 40));
        run(key, n);
        cyc += n;
      end
    end

    @(negedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
